bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the vending-machine display and credit path. It runs an iterative shift-add-3 (double-dabble) algorithm on a BIN_W-bit operand, one bit per clock. It uses a start/done handshake, flags values that do not fit in DIGITS decimal digits, and optionally emits a leading-zero blanking mask for the seven-segment driver. It replaces the fixed 8-bit, 3-digit combinational converter wherever wider credit/price values or registered timing are needed.

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bcd_dabble_digit.sv | 11 +
 rtl/bin2bcd_seq.sv | 142 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

endpackage : bin2bcd_pkg

// File: rtl/bcd_dabble_digit.sv
// Combinational double-dabble correction of one BCD digit: values of 5 and above gain 3.
module bcd_dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= DIGIT_W'(ADJ_THRESH)) ? digit_i + DIGIT_W'(ADJ_ADD) : digit_i;

endmodule : bcd_dabble_digit

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one operand bit per clock, start/done handshake.
// Optional leading-zero blanking mask output is built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]         blank
`endif
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               ovfScratch_q, ovfScratch_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   shifted;
  logic               carryOut;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (scratch_q[k*DIGIT_W +: DIGIT_W]),
      .digit_o (adjusted[k*DIGIT_W +: DIGIT_W])
    );
  end

  // The carry out of the top digit stands for 10^DIGITS and is dropped from the scratch value.
  assign shifted  = {adjusted[BCD_W-2:0], operand_q[BIN_W-1]};
  assign carryOut = adjusted[BCD_W-1];

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d, blankCalc;

  always_comb begin : blank_calc
    logic allZero;
    allZero   = 1'b1;
    blankCalc = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allZero      = allZero & (shifted[k*DIGIT_W +: DIGIT_W] == DIGIT_W'(0));
      blankCalc[k] = allZero;
    end
  end

  assign blank = blank_q;
`endif

  always_comb begin
    state_d      = state_q;
    operand_d    = operand_q;
    scratch_d    = scratch_q;
    ovfScratch_d = ovfScratch_q;
    count_d      = count_q;
    bcd_d        = bcd_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;
`ifdef BIN2BCD_BLANK_EN
    blank_d      = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d    = bin;
          scratch_d    = '0;
          ovfScratch_d = 1'b0;
          count_d      = CNT_W'(BIN_W);
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d    = shifted;
        operand_d    = operand_q << 1;
        ovfScratch_d = ovfScratch_q | carryOut;
        count_d      = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          bcd_d      = shifted;
          overflow_d = ovfScratch_q | carryOut;
          done_d     = 1'b1;
          state_d    = IDLE;
`ifdef BIN2BCD_BLANK_EN
          blank_d    = blankCalc;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      operand_q    <= '0;
      scratch_q    <= '0;
      ovfScratch_q <= 1'b0;
      count_q      <= '0;
      bcd_q        <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q      <= BLANK_RST;
`endif
    end else begin
      state_q      <= state_d;
      operand_q    <= operand_d;
      scratch_q    <= scratch_d;
      ovfScratch_q <= ovfScratch_d;
      count_q      <= count_d;
      bcd_q        <= bcd_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q      <= blank_d;
`endif
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq across four width/digit configurations.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;

  logic busyA, doneA, ovfA, busyB, doneB, ovfB, busyC, doneC, ovfC, busyD, doneD, ovfD;
  logic [11:0] bcdA;
  logic [7:0]  bcdB;
  logic [15:0] bcdC;
  logic [19:0] bcdD;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0] blankA;
  logic [1:0] blankB;
  logic [3:0] blankC;
  logic [4:0] blankD;
`endif

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dutA (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busyA), .done(doneA),
    .bcd(bcdA), .overflow(ovfA)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blankA)
`endif
  );
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dutB (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busyB), .done(doneB),
    .bcd(bcdB), .overflow(ovfB)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blankB)
`endif
  );
  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dutC (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16), .busy(busyC), .done(doneC),
    .bcd(bcdC), .overflow(ovfC)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blankC)
`endif
  );
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dutD (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16), .busy(busyD), .done(doneD),
    .bcd(bcdD), .overflow(ovfD)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blankD)
`endif
  );

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [31:0] blank;
    int          doneCyc;
  } exp_t;

  exp_t qA[$], qB[$], qC[$], qD[$];
  exp_t eA, eB, eC, eD;
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Each monitor pops the next expected result whenever its DUT pulses done.
  always @(negedge clk) if (!rst && doneA) begin
    if (qA.size() == 0) checkOutput("A spurious done", 32'(doneA), 32'd0);
    else begin
      eA = qA.pop_front();
      checkOutput("A bcd", 32'(bcdA), eA.bcd);
      checkOutput("A overflow", 32'(ovfA), 32'(eA.ovf));
      checkOutput("A done cycle", cyc, eA.doneCyc);
      checkOutput("A busy at done", 32'(busyA), 32'd0);
`ifdef BIN2BCD_BLANK_EN
      checkOutput("A blank", 32'(blankA), eA.blank);
`endif
    end
  end

  always @(negedge clk) if (!rst && doneB) begin
    if (qB.size() == 0) checkOutput("B spurious done", 32'(doneB), 32'd0);
    else begin
      eB = qB.pop_front();
      checkOutput("B bcd", 32'(bcdB), eB.bcd);
      checkOutput("B overflow", 32'(ovfB), 32'(eB.ovf));
      checkOutput("B done cycle", cyc, eB.doneCyc);
`ifdef BIN2BCD_BLANK_EN
      checkOutput("B blank", 32'(blankB), eB.blank);
`endif
    end
  end

  always @(negedge clk) if (!rst && doneC) begin
    if (qC.size() == 0) checkOutput("C spurious done", 32'(doneC), 32'd0);
    else begin
      eC = qC.pop_front();
      checkOutput("C bcd", 32'(bcdC), eC.bcd);
      checkOutput("C overflow", 32'(ovfC), 32'(eC.ovf));
      checkOutput("C done cycle", cyc, eC.doneCyc);
`ifdef BIN2BCD_BLANK_EN
      checkOutput("C blank", 32'(blankC), eC.blank);
`endif
    end
  end

  always @(negedge clk) if (!rst && doneD) begin
    if (qD.size() == 0) checkOutput("D spurious done", 32'(doneD), 32'd0);
    else begin
      eD = qD.pop_front();
      checkOutput("D bcd", 32'(bcdD), eD.bcd);
      checkOutput("D overflow", 32'(ovfD), 32'(eD.ovf));
      checkOutput("D done cycle", cyc, eD.doneCyc);
`ifdef BIN2BCD_BLANK_EN
      checkOutput("D blank", 32'(blankD), eD.blank);
`endif
    end
  end

  task automatic applyStimulus8(input logic [7:0] v,
                                input logic [11:0] bA, input logic oA, input logic [2:0] blA,
                                input logic [7:0] bB, input logic oB, input logic [1:0] blB,
                                input bit hold);
    int acc;
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk);
    #1;
    acc = cyc;
    qA.push_back('{32'(bA), oA, 32'(blA), acc + 8});
    qB.push_back('{32'(bB), oB, 32'(blB), acc + 8});
    checkOutput("A busy after accept", 32'(busyA), 32'd1);
    if (!hold) start8 = 1'b0;
  endtask

  task automatic applyStimulus16(input logic [15:0] v,
                                 input logic [15:0] bC, input logic oC, input logic [3:0] blC,
                                 input logic [19:0] bD, input logic oD, input logic [4:0] blD);
    int acc;
    @(negedge clk);
    start16 = 1'b1;
    bin16   = v;
    @(posedge clk);
    #1;
    acc = cyc;
    qC.push_back('{32'(bC), oC, 32'(blC), acc + 16});
    qD.push_back('{32'(bD), oD, 32'(blD), acc + 16});
    start16 = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busyA && !busyB && !busyC && !busyD &&
          qA.size() == 0 && qB.size() == 0 && qC.size() == 0 && qD.size() == 0) return;
    end
    checks++;
    $display("[TB] FAIL idle timeout: pending A=%0d B=%0d C=%0d D=%0d, required 0",
             qA.size(), qB.size(), qC.size(), qD.size());
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset done", 32'(doneA), 32'd0);
    checkOutput("reset bcd", 32'(bcdA), 32'd0);
    checkOutput("reset overflow", 32'(ovfB), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("reset blank A", 32'(blankA), 32'b110);
    checkOutput("reset blank C", 32'(blankC), 32'b1110);
`endif
    rst = 1'b0;

    applyStimulus8(8'd0, 12'h000, 1'b0, 3'b110, 8'h00, 1'b0, 2'b10, 1'b0);
    waitIdle();

    applyStimulus8(8'd255, 12'h255, 1'b0, 3'b000, 8'h55, 1'b1, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    bin8 = 8'd17;
    waitIdle();

    applyStimulus8(8'd99, 12'h099, 1'b0, 3'b100, 8'h99, 1'b0, 2'b00, 1'b1);
    bin8 = 8'd100;
    repeat (8) @(posedge clk);
    applyStimulus8(8'd100, 12'h100, 1'b0, 3'b000, 8'h00, 1'b1, 2'b10, 1'b0);
    waitIdle();

    applyStimulus8(8'd42, 12'h042, 1'b0, 3'b100, 8'h42, 1'b0, 2'b00, 1'b0);
    waitIdle();

    applyStimulus8(8'd200, 12'h200, 1'b0, 3'b000, 8'h00, 1'b1, 2'b10, 1'b0);
    qA.delete(qA.size() - 1);
    qB.delete(qB.size() - 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busyA), 32'd0);
    checkOutput("abort done", 32'(doneA), 32'd0);
    checkOutput("abort bcd A", 32'(bcdA), 32'd0);
    checkOutput("abort bcd B", 32'(bcdB), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("abort blank", 32'(blankA), 32'b110);
`endif
    repeat (12) @(negedge clk);
    applyStimulus8(8'd7, 12'h007, 1'b0, 3'b110, 8'h07, 1'b0, 2'b10, 1'b0);
    waitIdle();

    applyStimulus16(16'd65535, 16'h5535, 1'b1, 4'b0000, 20'h65535, 1'b0, 5'b00000);
    waitIdle();
    applyStimulus16(16'd10000, 16'h0000, 1'b1, 4'b1110, 20'h10000, 1'b0, 5'b00000);
    waitIdle();
    applyStimulus16(16'd1000, 16'h1000, 1'b0, 4'b0000, 20'h01000, 1'b0, 5'b10000);
    waitIdle();
    applyStimulus16(16'd0, 16'h0000, 1'b0, 4'b1110, 20'h00000, 1'b0, 5'b11110);
    waitIdle();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_bin2bcd_seq
